// File: rtl/b2a_share_arbiter.sv
// Issue controller and arbiter for one shared pipelined SecB2A core, with a tag pipeline for result routing.
// Define B2A_ARB_RR_EN for round-robin arbitration; without it, fixed priority applies and the lowest index wins.
module b2a_share_arbiter #(
  parameter int N_REQ     = 4,
  parameter int K_WIDTH   = 32,
  parameter int N_SHARES  = 8,
  parameter int MASKWIDTH = K_WIDTH * N_SHARES,
  parameter int LATENCY   = 33,
  localparam int ID_W     = $clog2(N_REQ),
  localparam int IF_W     = $clog2(LATENCY + 2)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req_vld,
  output logic [N_REQ-1:0]           req_rdy,
  input  logic [N_REQ*MASKWIDTH-1:0] req_b,
  input  logic                       rnd_vld,
  output logic                       core_rst_n,
  output logic                       core_dvld,
  output logic                       core_ena,
  output logic [MASKWIDTH-1:0]       core_b,
  input  logic [MASKWIDTH-1:0]       core_a,
  input  logic                       core_ovld,
  output logic                       rsp_vld,
  input  logic                       rsp_rdy,
  output logic [ID_W-1:0]            rsp_id,
  output logic [MASKWIDTH-1:0]       rsp_a,
  output logic [IF_W-1:0]            in_flight,
  output logic                       err
);

  logic            grant_vld;
  logic [ID_W-1:0] grant_idx;
  logic            retire;

  logic [LATENCY-1:0] tag_vld;
  logic [ID_W-1:0]    tag_id [LATENCY];

  // The whole pipeline advances only with fresh randomness and room in the response slot.
  assign core_rst_n = ~rst;
  assign core_ena   = rnd_vld & ~(rsp_vld & ~rsp_rdy);

`ifdef B2A_ARB_RR_EN
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] cand;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = ID_W'((int'(rr_ptr) + k) % N_REQ);
      if (!grant_vld && req_vld[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (core_dvld) begin
      rr_ptr <= (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end
`else
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!grant_vld && req_vld[k]) begin
        grant_vld = 1'b1;
        grant_idx = ID_W'(k);
      end
    end
  end
`endif

  always_comb begin
    req_rdy = '0;
    if (core_ena && grant_vld) req_rdy[grant_idx] = 1'b1;
  end

  assign core_dvld = |req_rdy;
  assign core_b    = core_dvld ? req_b[grant_idx*MASKWIDTH +: MASKWIDTH] : '0;
  assign retire    = core_ena & tag_vld[LATENCY-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      tag_vld <= '0;
    end else if (core_ena) begin
      for (int i = LATENCY - 1; i > 0; i--) tag_vld[i] <= tag_vld[i-1];
      tag_vld[0] <= core_dvld;
    end
  end

  // NOTE: the id array is left unreset; each entry is only meaningful when its tag_vld bit is set.
  always_ff @(posedge clk) begin
    if (core_ena) begin
      for (int i = LATENCY - 1; i > 0; i--) tag_id[i] <= tag_id[i-1];
      tag_id[0] <= grant_idx;
    end
  end

  // A retire only happens while core_ena is high, so an unaccepted response is never overwritten.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_vld <= 1'b0;
      rsp_id  <= '0;
      rsp_a   <= '0;
    end else if (retire) begin
      rsp_vld <= 1'b1;
      rsp_id  <= tag_id[LATENCY-1];
      rsp_a   <= core_a;
    end else if (rsp_rdy) begin
      rsp_vld <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_flight <= '0;
    end else begin
      case ({core_dvld, retire})
        2'b10:   in_flight <= in_flight + 1'b1;
        2'b01:   in_flight <= in_flight - 1'b1;
        default: in_flight <= in_flight;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else if (core_ena && (core_ovld != tag_vld[LATENCY-1])) begin
      err <= 1'b1;
    end
  end

endmodule
